// File: rtl/kv_replay_fifo.sv
// kv_replay_fifo: K/V row buffer with optional replay; rows read stay resident until released.
// The free-rows input is named release_req because release is a reserved word.
module kv_replay_fifo #(
    parameter int NUM_ENTRIES  = 64,
    parameter int ELEM_W       = 8,
    parameter int VEC_LEN      = 64,
    parameter int AFULL_THRESH = NUM_ENTRIES - 2,
    parameter int REPLAY_EN    = 1,
    localparam int AW = $clog2(NUM_ENTRIES),
    localparam int PW = AW + 1,
    localparam int DW = VEC_LEN * ELEM_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [PW-1:0] rd_idx,
    input  logic          rewind,
    input  logic          release_req,
    output logic [PW-1:0] occupancy,
    output logic [PW-1:0] pending,
    output logic          almost_full
);
    logic [DW-1:0] mem [NUM_ENTRIES];
    logic [PW-1:0] base_ptr, rd_ptr, wr_ptr, rd_ptr_n, base_ptr_n;
    logic wr_fire, rd_fire, do_rewind;

    assign occupancy   = wr_ptr - base_ptr;
    assign pending     = wr_ptr - rd_ptr;
    assign rd_idx      = rd_ptr - base_ptr;
    assign wr_ready    = occupancy != PW'(NUM_ENTRIES);
    assign rd_valid    = pending != '0;
    assign almost_full = occupancy >= PW'(AFULL_THRESH);
    assign rd_data     = mem[rd_ptr[AW-1:0]];
    assign wr_fire     = wr_valid && wr_ready;
    assign rd_fire     = rd_valid && rd_ready;
    assign do_rewind   = (REPLAY_EN != 0) && rewind;

    // In plain mode the base follows the read pointer, so every read frees its row.
    always_comb begin
        rd_ptr_n   = do_rewind ? base_ptr : rd_ptr + PW'(rd_fire);
        base_ptr_n = (REPLAY_EN == 0) ? rd_ptr_n :
                     (release_req && !rewind) ? rd_ptr_n : base_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_ptr <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            base_ptr <= base_ptr_n;
            rd_ptr   <= rd_ptr_n;
            wr_ptr   <= wr_ptr + PW'(wr_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: tb/tb_kv_replay_fifo.sv
// tb_kv_replay_fifo: directed replay/plain scenarios on N=8 instances plus a queue-model stress run at N=4.
module tb_kv_replay_fifo;
    logic clk = 0, rst = 0;
    logic wr_valid = 0, rd_ready = 0, rewind = 0, release_req = 0;
    logic [31:0] wr_data = '0;
    int checks = 0, failures = 0;

    logic d8_wr_ready, d8_rd_valid, d8_almost_full;
    logic [31:0] d8_rd_data;
    logic [3:0] d8_rd_idx, d8_occupancy, d8_pending;
    logic p8_wr_ready, p8_rd_valid, p8_almost_full;
    logic [31:0] p8_rd_data;
    logic [3:0] p8_rd_idx, p8_occupancy, p8_pending;
    logic d4_wr_ready, d4_rd_valid, d4_almost_full;
    logic [31:0] d4_rd_data;
    logic [2:0] d4_rd_idx, d4_occupancy, d4_pending;

    always #5 clk = ~clk;

    kv_replay_fifo #(.NUM_ENTRIES(8), .ELEM_W(8), .VEC_LEN(4), .REPLAY_EN(1)) d8 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(d8_wr_ready), .wr_data(wr_data),
        .rd_valid(d8_rd_valid), .rd_ready(rd_ready), .rd_data(d8_rd_data), .rd_idx(d8_rd_idx),
        .rewind(rewind), .release_req(release_req), .occupancy(d8_occupancy),
        .pending(d8_pending), .almost_full(d8_almost_full));

    kv_replay_fifo #(.NUM_ENTRIES(8), .ELEM_W(8), .VEC_LEN(4), .REPLAY_EN(0)) p8 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(p8_wr_ready), .wr_data(wr_data),
        .rd_valid(p8_rd_valid), .rd_ready(rd_ready), .rd_data(p8_rd_data), .rd_idx(p8_rd_idx),
        .rewind(rewind), .release_req(release_req), .occupancy(p8_occupancy),
        .pending(p8_pending), .almost_full(p8_almost_full));

    kv_replay_fifo #(.NUM_ENTRIES(4), .ELEM_W(8), .VEC_LEN(4), .AFULL_THRESH(3), .REPLAY_EN(1)) d4 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(d4_wr_ready), .wr_data(wr_data),
        .rd_valid(d4_rd_valid), .rd_ready(rd_ready), .rd_data(d4_rd_data), .rd_idx(d4_rd_idx),
        .rewind(rewind), .release_req(release_req), .occupancy(d4_occupancy),
        .pending(d4_pending), .almost_full(d4_almost_full));

    function automatic logic [31:0] row(input int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010203);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {wr_valid, rd_ready, rewind, release_req} = '0;
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic write_rows(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1;
            wr_data = row(first + i);
            step();
        end
        wr_valid = 0;
    endtask

    task automatic read_rows(input int n);
        rd_ready = 1;
        repeat (n) step();
        rd_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        wr_valid = 1;
        step();
        rst = 0;
        wr_valid = 0;
        checks++; if (d8_wr_ready !== 1'b1) begin failures++; $display("FAIL reset_wr_ready got=%b exp=1", d8_wr_ready); end
        checks++; if (d8_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", d8_rd_valid); end
        checks++; if (d8_rd_idx !== 4'd0) begin failures++; $display("FAIL reset_rd_idx got=%0d exp=0", d8_rd_idx); end
        checks++; if (d8_occupancy !== 4'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", d8_occupancy); end
        checks++; if (d8_pending !== 4'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", d8_pending); end
        checks++; if (d8_almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", d8_almost_full); end
        checks++; if (p8_occupancy !== 4'd0) begin failures++; $display("FAIL reset_p8_occupancy got=%0d exp=0", p8_occupancy); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1;
            wr_data = row(i);
            checks++; if (p8_almost_full !== (i >= 6)) begin failures++; $display("FAIL fill_almost_full occ=%0d got=%b exp=%b", i, p8_almost_full, i >= 6); end
            checks++; if (p8_wr_ready !== 1'b1) begin failures++; $display("FAIL fill_wr_ready occ=%0d got=%b exp=1", i, p8_wr_ready); end
            step();
        end
        wr_data = row(99);
        checks++; if (p8_wr_ready !== 1'b0) begin failures++; $display("FAIL full_wr_ready got=%b exp=0", p8_wr_ready); end
        checks++; if (p8_occupancy !== 4'd8) begin failures++; $display("FAIL full_occupancy got=%0d exp=8", p8_occupancy); end
        checks++; if (p8_almost_full !== 1'b1) begin failures++; $display("FAIL full_almost_full got=%b exp=1", p8_almost_full); end
        step();
        wr_valid = 0;
        checks++; if (p8_occupancy !== 4'd8) begin failures++; $display("FAIL drop_occupancy got=%0d exp=8", p8_occupancy); end
        rd_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (p8_rd_valid !== 1'b1) begin failures++; $display("FAIL drain_rd_valid i=%0d got=%b exp=1", i, p8_rd_valid); end
            checks++; if (p8_rd_data !== row(i)) begin failures++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, p8_rd_data, row(i)); end
            step();
        end
        rd_ready = 0;
        checks++; if (p8_rd_valid !== 1'b0) begin failures++; $display("FAIL drained_rd_valid got=%b exp=0", p8_rd_valid); end
        checks++; if (p8_occupancy !== 4'd0) begin failures++; $display("FAIL drained_occupancy got=%0d exp=0", p8_occupancy); end
    endtask

    task automatic test_replay();
        do_reset();
        write_rows(20, 5);
        rd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (d8_rd_idx !== 4'(i)) begin failures++; $display("FAIL replay_idx i=%0d got=%0d", i, d8_rd_idx); end
            checks++; if (d8_rd_data !== row(20 + i)) begin failures++; $display("FAIL replay_first_data i=%0d got=%h exp=%h", i, d8_rd_data, row(20 + i)); end
            step();
        end
        rd_ready = 0;
        checks++; if (d8_pending !== 4'd0) begin failures++; $display("FAIL replay_pending got=%0d exp=0", d8_pending); end
        checks++; if (d8_occupancy !== 4'd5) begin failures++; $display("FAIL replay_occupancy got=%0d exp=5", d8_occupancy); end
        rewind = 1;
        step();
        rewind = 0;
        checks++; if (d8_rd_data !== row(20)) begin failures++; $display("FAIL rewind_data got=%h exp=%h", d8_rd_data, row(20)); end
        checks++; if (d8_rd_idx !== 4'd0) begin failures++; $display("FAIL rewind_idx got=%0d exp=0", d8_rd_idx); end
        rd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (d8_rd_data !== row(20 + i)) begin failures++; $display("FAIL replay_second_data i=%0d got=%h exp=%h", i, d8_rd_data, row(20 + i)); end
            checks++; if (d8_wr_ready !== 1'b1) begin failures++; $display("FAIL replay_wr_ready got=%b exp=1", d8_wr_ready); end
            step();
        end
        rd_ready = 0;
        checks++; if (d8_rd_valid !== 1'b0) begin failures++; $display("FAIL replay_end_valid got=%b exp=0", d8_rd_valid); end
    endtask

    task automatic test_release();
        do_reset();
        write_rows(40, 8);
        read_rows(3);
        checks++; if (d8_occupancy !== 4'd8) begin failures++; $display("FAIL rel_pre_occupancy got=%0d exp=8", d8_occupancy); end
        checks++; if (d8_wr_ready !== 1'b0) begin failures++; $display("FAIL rel_pre_wr_ready got=%b exp=0", d8_wr_ready); end
        release_req = 1;
        checks++; if (d8_wr_ready !== 1'b0) begin failures++; $display("FAIL rel_same_cycle_wr_ready got=%b exp=0", d8_wr_ready); end
        step();
        release_req = 0;
        checks++; if (d8_occupancy !== 4'd5) begin failures++; $display("FAIL rel_occupancy got=%0d exp=5", d8_occupancy); end
        checks++; if (d8_wr_ready !== 1'b1) begin failures++; $display("FAIL rel_wr_ready got=%b exp=1", d8_wr_ready); end
        checks++; if (d8_rd_idx !== 4'd0) begin failures++; $display("FAIL rel_idx got=%0d exp=0", d8_rd_idx); end
        read_rows(2);
        rewind = 1;
        step();
        rewind = 0;
        checks++; if (d8_rd_data !== row(43)) begin failures++; $display("FAIL rel_rewind_data got=%h exp=%h", d8_rd_data, row(43)); end
        checks++; if (d8_pending !== 4'd5) begin failures++; $display("FAIL rel_rewind_pending got=%0d exp=5", d8_pending); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        write_rows(60, 4);
        read_rows(2);
        {rewind, release_req, rd_ready} = 3'b111;
        step();
        {rewind, release_req, rd_ready} = 3'b000;
        checks++; if (d8_rd_idx !== 4'd0) begin failures++; $display("FAIL sim_idx got=%0d exp=0", d8_rd_idx); end
        checks++; if (d8_occupancy !== 4'd4) begin failures++; $display("FAIL sim_occupancy got=%0d exp=4", d8_occupancy); end
        checks++; if (d8_rd_data !== row(60)) begin failures++; $display("FAIL sim_data got=%h exp=%h", d8_rd_data, row(60)); end
        do_reset();
        write_rows(70, 1);
        wr_valid = 1;
        wr_data = row(71);
        rd_ready = 1;
        step();
        {wr_valid, rd_ready} = 2'b00;
        checks++; if (d8_pending !== 4'd1) begin failures++; $display("FAIL wr_rd_pending got=%0d exp=1", d8_pending); end
        checks++; if (d8_occupancy !== 4'd2) begin failures++; $display("FAIL wr_rd_occupancy got=%0d exp=2", d8_occupancy); end
        checks++; if (d8_rd_data !== row(71)) begin failures++; $display("FAIL wr_rd_data got=%h exp=%h", d8_rd_data, row(71)); end
        checks++; if (p8_occupancy !== 4'd1) begin failures++; $display("FAIL wr_rd_p8_occupancy got=%0d exp=1", p8_occupancy); end
    endtask

    task automatic test_wrap_stress();
        logic [31:0] q[$];
        int nread, occ, pend, nr;
        bit wf, rf;
        do_reset();
        nread = 0;
        for (int c = 0; c < 10000; c++) begin
            wr_valid = ($urandom_range(0, 9) < 7);
            rd_ready = ($urandom_range(0, 9) < 6);
            rewind = ($urandom_range(0, 15) == 0);
            release_req = ($urandom_range(0, 7) == 0);
            wr_data = $urandom;
            occ = q.size();
            pend = occ - nread;
            checks++; if (d4_occupancy !== 3'(occ)) begin failures++; $display("FAIL wrap_occupancy c=%0d got=%0d exp=%0d", c, d4_occupancy, occ); end
            checks++; if (d4_pending !== 3'(pend)) begin failures++; $display("FAIL wrap_pending c=%0d got=%0d exp=%0d", c, d4_pending, pend); end
            checks++; if (d4_rd_idx !== 3'(nread)) begin failures++; $display("FAIL wrap_idx c=%0d got=%0d exp=%0d", c, d4_rd_idx, nread); end
            checks++; if (d4_wr_ready !== (occ < 4)) begin failures++; $display("FAIL wrap_wr_ready c=%0d got=%b exp=%b", c, d4_wr_ready, occ < 4); end
            checks++; if (d4_rd_valid !== (pend > 0)) begin failures++; $display("FAIL wrap_rd_valid c=%0d got=%b exp=%b", c, d4_rd_valid, pend > 0); end
            checks++; if (d4_almost_full !== (occ >= 3)) begin failures++; $display("FAIL wrap_almost_full c=%0d got=%b exp=%b", c, d4_almost_full, occ >= 3); end
            if (pend > 0) begin
                checks++; if (d4_rd_data !== q[nread]) begin failures++; $display("FAIL wrap_data c=%0d got=%h exp=%h", c, d4_rd_data, q[nread]); end
            end
            wf = wr_valid && occ < 4;
            rf = rd_ready && pend > 0;
            nr = rewind ? 0 : nread + int'(rf);
            if (release_req && !rewind) begin
                repeat (nr) void'(q.pop_front());
                nr = 0;
            end
            if (wf) q.push_back(wr_data);
            nread = nr;
            step();
        end
        {wr_valid, rd_ready, rewind, release_req} = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_rows(80, 6);
        wr_valid = 1;
        wr_data = row(86);
        rst = 1;
        step();
        rst = 0;
        wr_valid = 0;
        checks++; if (d8_occupancy !== 4'd0) begin failures++; $display("FAIL mid_rst_occupancy got=%0d exp=0", d8_occupancy); end
        checks++; if (d8_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_rd_valid got=%b exp=0", d8_rd_valid); end
        checks++; if (d8_wr_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_wr_ready got=%b exp=1", d8_wr_ready); end
        write_rows(90, 1);
        checks++; if (d8_rd_valid !== 1'b1) begin failures++; $display("FAIL post_rst_rd_valid got=%b exp=1", d8_rd_valid); end
        checks++; if (d8_rd_data !== row(90)) begin failures++; $display("FAIL post_rst_data got=%h exp=%h", d8_rd_data, row(90)); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_replay();
        test_release();
        test_simultaneous();
        test_wrap_stress();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
